// File: rtl/frame_sequencer_if.sv
// ============================================================================
// Module   : frame_sequencer_if
// Purpose  : Bundles the control, configuration, readout handshake and status
//            signals of the frame sequencer.
// Ports    : slave modport  - sequencer side (config/control/ro_busy in,
//                              trigger/exposure/status out)
//            master modport - controller / readout side (mirror of slave)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_sequencer_if #(
  parameter int EXP_W = 24
);
  // control and configuration
  logic             start;
  logic             abort;
  logic             continuous;
  logic [15:0]      num_frame;
  logic [EXP_W-1:0] t_exp;
  logic [15:0]      t_gap;
  // readout handshake
  logic             ro_busy;
  logic             ro_trigger;
  // status
  logic             exp_en;
  logic             busy;
  logic [15:0]      frame_cnt;
  logic             done;
  logic             timeout_err;

  modport slave (
    input  start, abort, continuous, num_frame, t_exp, t_gap, ro_busy,
    output ro_trigger, exp_en, busy, frame_cnt, done, timeout_err
  );

  modport master (
    output start, abort, continuous, num_frame, t_exp, t_gap, ro_busy,
    input  ro_trigger, exp_en, busy, frame_cnt, done, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/frame_sequencer.sv
// ============================================================================
// Module   : frame_sequencer
// Purpose  : Runs a sequence of exposure frames: exposure window, readout
//            trigger, wait for the readout engine to acknowledge and finish,
//            optional gap, repeat. Supports fixed-count and continuous modes,
//            safe abort and a readout-acknowledge timeout.
// Ports    : clk   - system clock
//            rst_n - asynchronous active-low reset
//            bus   - frame_sequencer_if.slave (config, control, handshake,
//                    status)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_sequencer #(
  parameter int BUSY_TIMEOUT = 1000,
  parameter int EXP_W        = 24
) (
  input  wire               clk,
  input  wire               rst_n,
  frame_sequencer_if.slave  bus
);

  localparam int AW    = $clog2(BUSY_TIMEOUT + 1);
  localparam int TMR_W = (EXP_W > 16) ? ((EXP_W > AW) ? EXP_W : AW)
                                      : ((16 > AW) ? 16 : AW);
  // The acknowledge timer is loaded on entry to WAIT_ACK, one cycle after the
  // trigger rose, so it counts down from BUSY_TIMEOUT-2 to land the timeout
  // exactly BUSY_TIMEOUT cycles after the trigger.
  localparam logic [TMR_W-1:0] ACK_LOAD =
    (BUSY_TIMEOUT > 2) ? TMR_W'(BUSY_TIMEOUT - 2) : '0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXPOSE   = 3'd1,
    S_TRIG     = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_WAIT_RO  = 3'd4,
    S_GAP      = 3'd5,
    S_DRAIN    = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [15:0]      frame_cnt_q, frame_cnt_nxt;
  logic             trig_q, trig_nxt;
  logic             done_q, done_nxt;
  logic             tmo_q, tmo_nxt;
  logic             exp_en_q, busy_q;
  logic             load_cfg;
  logic             ready;

  // latched configuration
  logic             cont_q;
  logic [15:0]      nframe_q;
  logic [EXP_W-1:0] texp_q;
  logic [15:0]      tgap_q;

  logic [EXP_W-1:0] texp_src;
  logic [TMR_W-1:0] exp_load;

  // In IDLE the exposure length comes straight from the port because it is
  // being latched on the same edge.
  assign texp_src = (state == S_IDLE) ? bus.t_exp : texp_q;
  assign exp_load = (texp_src == '0) ? '0 : (TMR_W'(texp_src) - TMR_W'(1));

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    frame_cnt_nxt = frame_cnt_q;
    trig_nxt      = 1'b0;
    done_nxt      = 1'b0;
    tmo_nxt       = tmo_q;
    load_cfg      = 1'b0;

    case (state)
      S_IDLE: begin
        if (ready && bus.start && !bus.abort) begin
          if (bus.continuous || (bus.num_frame != 16'd0)) begin
            load_cfg      = 1'b1;
            frame_cnt_nxt = '0;
            tmo_nxt       = 1'b0;
            timer_nxt     = exp_load;
            state_nxt     = S_EXPOSE;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end

      S_EXPOSE: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else if (timer == '0) begin
          state_nxt = S_TRIG;
          trig_nxt  = !bus.ro_busy;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end

      // The trigger is held off while the readout engine still reports busy,
      // so TRIG lasts one cycle in the normal case and longer otherwise.
      S_TRIG: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else if (trig_q) begin
          state_nxt = S_WAIT_ACK;
          timer_nxt = ACK_LOAD;
        end else begin
          trig_nxt = !bus.ro_busy;
        end
      end

      S_WAIT_ACK: begin
        if (bus.abort) begin
          state_nxt = S_DRAIN;
        end else if (bus.ro_busy) begin
          state_nxt = S_WAIT_RO;
        end else if (timer == '0) begin
          tmo_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end

      S_WAIT_RO: begin
        if (bus.abort) begin
          state_nxt = S_DRAIN;
        end else if (!bus.ro_busy) begin
          frame_cnt_nxt = frame_cnt_q + 16'd1;
          if (!cont_q && (frame_cnt_nxt == nframe_q)) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else if (tgap_q == 16'd0) begin
            timer_nxt = exp_load;
            state_nxt = S_EXPOSE;
          end else begin
            timer_nxt = TMR_W'(tgap_q) - TMR_W'(1);
            state_nxt = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else if (timer == '0) begin
          timer_nxt = exp_load;
          state_nxt = S_EXPOSE;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end

      S_DRAIN: begin
        if (!bus.ro_busy) begin
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      frame_cnt_q <= '0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      exp_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      ready       <= 1'b0;
      cont_q      <= 1'b0;
      nframe_q    <= '0;
      texp_q      <= '0;
      tgap_q      <= '0;
    end else begin
      // ready keeps the first edge after reset release from starting a run
      ready       <= 1'b1;
      state       <= state_nxt;
      timer       <= timer_nxt;
      frame_cnt_q <= frame_cnt_nxt;
      trig_q      <= trig_nxt;
      done_q      <= done_nxt;
      tmo_q       <= tmo_nxt;
      exp_en_q    <= (state_nxt == S_EXPOSE);
      busy_q      <= (state_nxt != S_IDLE);
      if (load_cfg) begin
        cont_q   <= bus.continuous;
        nframe_q <= bus.num_frame;
        texp_q   <= bus.t_exp;
        tgap_q   <= bus.t_gap;
      end
    end
  end

  assign bus.ro_trigger  = trig_q;
  assign bus.exp_en      = exp_en_q;
  assign bus.busy        = busy_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_sequencer.sv
// ============================================================================
// Module   : tb_frame_sequencer
// Purpose  : Self-checking bench for frame_sequencer with a readout-engine
//            model and an exposure-length scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_sequencer;

  logic clk;
  logic rst_n;
  logic ro_auto;
  logic model_busy;
  logic man_busy;

  int checks;
  int failures;
  int cyc;
  int run_len;
  int last_exp;
  int trig_cnt;
  int done_cnt;
  int viol;
  int exp_q[$];

  frame_sequencer_if #(.EXP_W(24)) bus ();

  frame_sequencer #(
    .BUSY_TIMEOUT(1000),
    .EXP_W       (24)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.ro_busy = ro_auto ? model_busy : man_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Readout engine: goes busy two cycles after a trigger, for 2..48 cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ro_auto && bus.ro_trigger) begin
        repeat (2) @(negedge clk);
        model_busy = 1'b1;
        repeat ($urandom_range(2, 48)) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.exp_en) run_len++;
    else if (run_len != 0) begin
      last_exp = run_len;
      run_len  = 0;
    end
    if (bus.ro_trigger) begin
      trig_cnt++;
      if (bus.exp_en || bus.ro_busy) viol++;
    end
    if (bus.done) done_cnt++;
  endtask

  task automatic clear_stats();
    run_len  = 0;
    last_exp = 0;
    trig_cnt = 0;
    done_cnt = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.ro_trigger, bus.exp_en, bus.busy, bus.done, bus.timeout_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000",
               {bus.ro_trigger, bus.exp_en, bus.busy, bus.done, bus.timeout_err});
    end
    checks++;
    if (bus.frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_frame_cnt got=%0d want=0", bus.frame_cnt);
    end
  endtask

  // Fixed-count sequence; config inputs are scrambled after start.
  task automatic run_sequence(input logic [15:0] nf, input logic [23:0] te,
                              input logic [15:0] tg);
    int guard;
    int e;
    clear_stats();
    for (int i = 0; i < int'(nf); i++) exp_q.push_back((te == 0) ? 1 : int'(te));
    bus.continuous = 1'b0;
    bus.num_frame  = nf;
    bus.t_exp      = te;
    bus.t_gap      = tg;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
    bus.num_frame  = 16'd9;
    bus.t_exp      = 24'd2;
    bus.t_gap      = 16'd1;
    guard = 0;
    while (done_cnt == 0 && guard < 5000) begin
      step();
      guard++;
      if (bus.ro_trigger) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL seq_extra_trigger got=trigger want=none");
        end else begin
          e = exp_q.pop_front();
          if (last_exp !== e) begin
            failures++;
            $display("FAIL seq_exp_len got=%0d want=%0d", last_exp, e);
          end
        end
      end
    end
    checks++;
    if (guard >= 5000) begin
      failures++;
      $display("FAIL seq_done_timeout got=no_done want=done");
    end
    step();
    step();
    checks++;
    if (bus.frame_cnt !== nf) begin
      failures++;
      $display("FAIL seq_frame_cnt got=%0d want=%0d", bus.frame_cnt, nf);
    end
    checks++;
    if (done_cnt !== 1 || trig_cnt !== int'(nf)) begin
      failures++;
      $display("FAIL seq_counts got=done%0d/trig%0d want=done1/trig%0d",
               done_cnt, trig_cnt, nf);
    end
    checks++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL seq_end got=busy%b/left%0d want=busy0/left0",
               bus.busy, exp_q.size());
    end
  endtask

  task automatic test_normal();
    ro_auto = 1'b1;
    run_sequence(16'd3, 24'd10, 16'd5);
  endtask

  task automatic test_timeout();
    int guard;
    int t0;
    clear_stats();
    ro_auto       = 1'b0;
    man_busy      = 1'b0;
    bus.num_frame = 16'd1;
    bus.t_exp     = 24'd4;
    bus.t_gap     = 16'd0;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    guard = 0;
    while (!bus.ro_trigger && guard < 100) begin
      step();
      guard++;
    end
    t0 = cyc;
    guard = 0;
    while (!bus.timeout_err && guard < 1200) begin
      step();
      guard++;
    end
    checks++;
    if (cyc - t0 !== 1000) begin
      failures++;
      $display("FAIL timeout_delay got=%0d want=1000", cyc - t0);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1 || done_cnt !== 0) begin
      failures++;
      $display("FAIL timeout_state got=busy%b/err%b/done%0d want=busy0/err1/done0",
               bus.busy, bus.timeout_err, done_cnt);
    end
    ro_auto = 1'b1;
  endtask

  task automatic test_abort_expose();
    clear_stats();
    bus.num_frame = 16'd2;
    bus.t_exp     = 24'd20;
    bus.t_gap     = 16'd3;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    checks++;
    if (bus.exp_en !== 1'b1 || bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL abexp_pre got=exp%b/err%b want=exp1/err0", bus.exp_en, bus.timeout_err);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    checks++;
    if (bus.exp_en !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL abexp_post got=exp%b/busy%b want=exp0/busy0", bus.exp_en, bus.busy);
    end
    repeat (30) step();
    checks++;
    if (trig_cnt !== 0) begin
      failures++;
      $display("FAIL abexp_trig got=%0d want=0", trig_cnt);
    end
  endtask

  task automatic test_abort_wait_ro();
    int guard;
    int low_seen;
    clear_stats();
    ro_auto       = 1'b0;
    man_busy      = 1'b0;
    bus.num_frame = 16'd3;
    bus.t_exp     = 24'd3;
    bus.t_gap     = 16'd2;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    guard = 0;
    while (!bus.ro_trigger && guard < 100) begin
      step();
      guard++;
    end
    repeat (2) step();
    man_busy = 1'b1;
    repeat (3) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    low_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!bus.busy) low_seen++;
    end
    checks++;
    if (low_seen !== 0) begin
      failures++;
      $display("FAIL abro_busy_held got=%0d_low_cycles want=0", low_seen);
    end
    man_busy = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.frame_cnt !== 16'd0 || done_cnt !== 0) begin
      failures++;
      $display("FAIL abro_end got=busy%b/fc%0d/done%0d want=busy0/fc0/done0",
               bus.busy, bus.frame_cnt, done_cnt);
    end
    ro_auto = 1'b1;
  endtask

  task automatic test_continuous();
    int guard;
    int e;
    clear_stats();
    for (int i = 0; i < 5; i++) exp_q.push_back(1);
    bus.continuous = 1'b1;
    bus.num_frame  = 16'd0;
    bus.t_exp      = 24'd0;
    bus.t_gap      = 16'd0;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    guard = 0;
    while (bus.frame_cnt != 16'd5 && guard < 2000) begin
      step();
      guard++;
      if (bus.ro_trigger) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL cont_extra_trigger got=trigger want=none");
        end else begin
          e = exp_q.pop_front();
          if (last_exp !== e) begin
            failures++;
            $display("FAIL cont_exp_len got=%0d want=%0d", last_exp, e);
          end
        end
      end
    end
    bus.abort = 1'b1;
    step();
    bus.abort      = 1'b0;
    bus.continuous = 1'b0;
    repeat (5) step();
    checks++;
    if (bus.frame_cnt !== 16'd5 || trig_cnt !== 5) begin
      failures++;
      $display("FAIL cont_frames got=fc%0d/trig%0d want=fc5/trig5", bus.frame_cnt, trig_cnt);
    end
    checks++;
    if (done_cnt !== 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL cont_end got=done%0d/busy%b want=done0/busy0", done_cnt, bus.busy);
    end
  endtask

  task automatic test_reset_mid_gap();
    int guard;
    clear_stats();
    bus.num_frame = 16'd3;
    bus.t_exp     = 24'd10;
    bus.t_gap     = 16'd20;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    guard = 0;
    while (bus.frame_cnt != 16'd1 && guard < 500) begin
      step();
      guard++;
    end
    repeat (3) step();
    checks++;
    if (bus.busy !== 1'b1 || bus.exp_en !== 1'b0) begin
      failures++;
      $display("FAIL gap_pre got=busy%b/exp%b want=busy1/exp0", bus.busy, bus.exp_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ro_trigger, bus.exp_en, bus.busy, bus.done, bus.timeout_err} !== 5'b0 ||
        bus.frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL gap_async_reset got=%b/fc%0d want=00000/fc0",
               {bus.ro_trigger, bus.exp_en, bus.busy, bus.done, bus.timeout_err},
               bus.frame_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    run_sequence(16'd3, 24'd10, 16'd5);
  endtask

  task automatic test_zero_frames();
    clear_stats();
    bus.num_frame = 16'd0;
    bus.t_exp     = 24'd5;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_done got=done%b/busy%b want=done1/busy0", bus.done, bus.busy);
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_after got=done%b/busy%b want=done0/busy0", bus.done, bus.busy);
    end
  endtask

  task automatic test_start_abort();
    clear_stats();
    bus.num_frame = 16'd3;
    bus.t_exp     = 24'd4;
    bus.start     = 1'b1;
    bus.abort     = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.busy !== 1'b0 || bus.exp_en !== 1'b0 || done_cnt !== 0) begin
      failures++;
      $display("FAIL start_abort got=busy%b/exp%b/done%0d want=busy0/exp0/done0",
               bus.busy, bus.exp_en, done_cnt);
    end
  endtask

  task automatic test_trigger_safety();
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL trigger_overlap got=%0d want=0", viol);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    viol           = 0;
    ro_auto        = 1'b1;
    man_busy       = 1'b0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.continuous = 1'b0;
    bus.num_frame  = 16'd0;
    bus.t_exp      = 24'd0;
    bus.t_gap      = 16'd0;
    clear_stats();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    step();
    step();
    test_normal();
    test_timeout();
    test_abort_expose();
    test_abort_wait_ro();
    test_continuous();
    test_reset_mid_gap();
    test_zero_frames();
    test_start_abort();
    test_trigger_safety();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter: BUSY_TIMEOUT, default 1000, max CLK cycles allowed from ro_trigger until ro_busy asserts.
REQ-002 Parameter: EXP_W, default 24, width of t_exp.
REQ-003 CLK  input  1  system clock, 100 MHz domain shared with the readout engine.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a sequence; honoured only in IDLE.
REQ-006 abort  input  1  level; terminate the sequence safely.
REQ-007 continuous  input  1  1 = run frames until abort, ignoring num_frame.
REQ-008 num_frame  input  16  frames per sequence.
REQ-009 t_exp  input  EXP_W  exposure length in CLK cycles.
REQ-010 t_gap  input  16  idle cycles between frames.
REQ-011 ro_busy  input  1  readout engine busy flag (re_busy).
REQ-012 ro_trigger  output  1  one-cycle readout trigger.
REQ-013 exp_en  output  1  exposure window enable.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 frame_cnt  output  16  frames completed in the current sequence.
REQ-016 done  output  1  one-cycle pulse on normal sequence completion.
REQ-017 timeout_err  output  1  sticky readout-acknowledge timeout flag.

Function
REQ-018 States SHALL be IDLE, EXPOSE, TRIG, WAIT_ACK, WAIT_RO, GAP, DRAIN; all outputs are registered.
REQ-019 start in IDLE with continuous=1 or num_frame!=0 SHALL latch continuous, num_frame, t_exp and t_gap, clear frame_cnt and timeout_err, and enter EXPOSE on the next cycle.
REQ-020 start in IDLE with continuous=0 and num_frame=0 SHALL produce a done pulse on the next cycle and stay in IDLE.
REQ-021 Config input changes during a sequence SHALL have no effect until the next start.
REQ-022 EXPOSE SHALL hold exp_en=1 for exactly max(t_exp,1) cycles, then enter TRIG.
REQ-023 TRIG SHALL assert ro_trigger for exactly one cycle, then enter WAIT_ACK.
REQ-024 WAIT_ACK SHALL enter WAIT_RO on the first cycle ro_busy=1.
REQ-025 If ro_busy stays 0 for BUSY_TIMEOUT cycles in WAIT_ACK, the block SHALL set timeout_err, enter IDLE, and not pulse done.
REQ-026 WAIT_RO SHALL, on the first cycle ro_busy=0, increment frame_cnt, with 16-bit wrap in continuous mode.
REQ-027 After that increment, if continuous=0 and frame_cnt equals num_frame, the block SHALL pulse done and enter IDLE.
REQ-028 Otherwise the block SHALL enter GAP for t_gap cycles and then EXPOSE; t_gap=0 SHALL go directly to EXPOSE.
REQ-029 abort in IDLE, EXPOSE, TRIG or GAP SHALL enter IDLE on the next cycle, drop exp_en, and suppress any pending ro_trigger.
REQ-030 abort in WAIT_ACK or WAIT_RO SHALL enter DRAIN.
REQ-031 DRAIN SHALL wait for ro_busy=0 and then enter IDLE, without incrementing frame_cnt and without pulsing done.
REQ-032 When abort and frame completion occur in the same cycle, abort SHALL take priority.
REQ-033 When start and abort are high together in IDLE, the block SHALL stay in IDLE.
REQ-034 The block SHALL never assert ro_trigger while ro_busy=1 or while exp_en=1.

Reset
REQ-035 rst_n=0 SHALL asynchronously force IDLE and drive ro_trigger, exp_en, busy, done, timeout_err and frame_cnt to 0, including mid-sequence.
REQ-036 After rst_n deasserts, the first state transition SHALL occur on a CLK edge at least one cycle later.

Verification
REQ-037 num_frame=3, t_exp=10, t_gap=5, ro_busy model high 2 to 50 cycles after trigger -> 3 ro_trigger pulses each preceded by 10 cycles of exp_en; frame_cnt ends at 3; one done pulse; busy then low.
REQ-038 ro_busy held 0 with BUSY_TIMEOUT=1000 -> timeout_err=1 exactly 1000 cycles after ro_trigger; state IDLE; no done pulse.
REQ-039 abort asserted mid-EXPOSE -> exp_en low next cycle; no ro_trigger; busy low.
REQ-040 abort asserted in WAIT_RO with ro_busy=1 -> busy stays high until ro_busy falls; frame_cnt unchanged; no done pulse.
REQ-041 continuous=1, t_exp=0, t_gap=0 for 5 frames, then abort -> exp_en 1-cycle windows; frame_cnt=5; no done pulse.
REQ-042 rst_n pulsed low during GAP -> all outputs 0 immediately; a new start behaves as in REQ-037.
